// File: rtl/hsi_rx_bridge.sv
// Buffers decoded HSI words and emits each as {tag|src} header byte plus data bytes MSB-first.
// Header appears 2 cycles after the strobe; out_d/out_rdy hold until out_ack; words arriving while full are counted and dropped.
module hsi_rx_bridge #(
    parameter int          WORD_W     = 16,
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [7:0]  HDR_TAG    = 8'hA4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [1:0]            in_src,
    input  logic [WORD_W-1:0]     in_data,
    output logic [7:0]            out_d,
    output logic                  out_rdy,
    input  logic                  out_ack,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [7:0]            ovf_cnt,
    output logic                  busy
);

    localparam int NB    = WORD_W / 8;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = $clog2(NB + 1);
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [CW-1:0]       NB_C     = CW'(NB);
    localparam logic [CW-1:0]       ONE_C    = CW'(1);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t                  state, state_nxt;
    logic [WORD_W+1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [WORD_W+1:0]       head;
    logic                    full, push, pop;
    logic [WORD_W-1:0]       sh_data, sh_next;
    logic [CW-1:0]           byte_cnt;

    // full uses the registered level, so a same-cycle pop cannot rescue a word
    assign full    = (fifo_level == FULL_LVL);
    assign push    = in_valid && !full;
    assign pop     = (state == IDLE) && (fifo_level != '0);
    assign head    = mem[rd_ptr];
    assign sh_next = sh_data << 8;
    assign busy    = (state != IDLE) || (fifo_level != '0);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_src, in_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            ovf_cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (in_valid && full && (ovf_cnt != 8'hFF))
                ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = HDR;
            HDR:     if (out_ack) state_nxt = DATA;
            DATA:    if (out_ack && (byte_cnt == ONE_C)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // out_d is loaded one step ahead so the byte on the bus is always registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_d    <= '0;
            out_rdy  <= 1'b0;
            sh_data  <= '0;
            byte_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        out_d    <= {HDR_TAG[7:2], head[WORD_W+1:WORD_W]};
                        out_rdy  <= 1'b1;
                        sh_data  <= head[WORD_W-1:0];
                        byte_cnt <= NB_C;
                    end
                end
                HDR: begin
                    if (out_ack)
                        out_d <= sh_data[WORD_W-1 -: 8];
                end
                DATA: begin
                    if (out_ack) begin
                        if (byte_cnt == ONE_C) begin
                            out_rdy <= 1'b0;
                        end else begin
                            out_d    <= sh_next[WORD_W-1 -: 8];
                            sh_data  <= sh_next;
                            byte_cnt <= byte_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    out_rdy <= 1'b0;
                end
            endcase
        end
    end

endmodule
